// File: rtl/logic_unit_pkg.sv
// Shared constants for the logic unit pipeline: op codes, output buffer
// depth and the parity helper used when LOGIC_UNIT_PARITY_EN is defined.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND      = 3'b000;
    localparam logic [2:0] OP_OR       = 3'b001;
    localparam logic [2:0] OP_XOR      = 3'b010;
    localparam logic [2:0] OP_NOR      = 3'b011;
    localparam logic [2:0] OP_XNOR     = 3'b100;
    localparam logic [2:0] OP_ANDN     = 3'b101;
    localparam logic [2:0] OP_ACC_XOR  = 3'b110;
    localparam logic [2:0] OP_ACC_LOAD = 3'b111;

    localparam int BUF_DEPTH = 2;

    // Even parity over up to 64 bits; narrower values are zero-extended by the caller.
    function automatic logic parity64(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/logic_unit_fifo2.sv
// Two-entry result buffer with registered ready/valid/data outputs.
// The write side is gated internally (ready and no flush); the accept strobe
// is exported so the owner can qualify side effects such as accumulator updates.
module logic_unit_fifo2
    import logic_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         wr_ready,
    output logic         wr_accept,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    input  logic         rd_ready
);

    logic [W-1:0] mem_r [BUF_DEPTH];
    logic [1:0]   count_r;
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic         ready_r;
    logic         valid_r;
    logic [W-1:0] data_r;

    logic         push_s;
    logic         pop_s;
    logic [1:0]   count_nxt_s;
    logic         wr_ptr_nxt_s;
    logic         rd_ptr_nxt_s;
    logic [W-1:0] head_nxt_s;

    // Next-state for occupancy, pointers and the head word presented after the edge.
    always_comb begin
        push_s       = wr_valid && ready_r && !flush;
        pop_s        = valid_r && rd_ready;
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = data_r;
        if (flush) begin
            count_nxt_s  = 2'd0;
            wr_ptr_nxt_s = 1'b0;
            rd_ptr_nxt_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = ~wr_ptr_r;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = ~rd_ptr_r;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + 2'd1;
                2'b01:   count_nxt_s = count_r - 2'd1;
                default: count_nxt_s = count_r;
            endcase
            // The new head is either the word being written now or a stored one;
            // when the buffer drains the last word is simply held.
            if (count_nxt_s != 2'd0) begin
                if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                    head_nxt_s = wr_data;
                end else begin
                    head_nxt_s = mem_r[rd_ptr_nxt_s];
                end
            end else begin
                head_nxt_s = data_r;
            end
        end
    end

    // Buffer state and registered handshake/data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
            end
            count_r  <= count_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            ready_r  <= (count_nxt_s < 2'(BUF_DEPTH)) && !flush;
            valid_r  <= (count_nxt_s != 2'd0);
            data_r   <= head_nxt_s;
        end
    end

    assign wr_ready  = ready_r;
    assign wr_accept = push_s;
    assign rd_valid  = valid_r;
    assign rd_data   = data_r;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with an XOR accumulator and a 2-entry output buffer.
// Optional feature: define LOGIC_UNIT_PARITY_EN to add the out_parity port,
// carried alongside each buffered result.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

`ifdef LOGIC_UNIT_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic             acc_wr_s;
    logic [WIDTH-1:0] result_s;
    logic [PW-1:0]    wr_payload_s;
    logic [PW-1:0]    rd_payload_s;
    logic             accept_s;

    // Op decode; accumulator ops produce the updated accumulator as their result.
    always_comb begin
        acc_nxt_s = acc_r;
        acc_wr_s  = 1'b0;
        result_s  = '0;
        case (in_op)
            OP_AND:      result_s = in_a & in_b;
            OP_OR:       result_s = in_a | in_b;
            OP_XOR:      result_s = in_a ^ in_b;
            OP_NOR:      result_s = ~(in_a | in_b);
            OP_XNOR:     result_s = ~(in_a ^ in_b);
            OP_ANDN:     result_s = in_a & ~in_b;
            OP_ACC_XOR: begin
                acc_nxt_s = acc_r ^ in_a ^ in_b;
                acc_wr_s  = 1'b1;
                result_s  = acc_nxt_s;
            end
            OP_ACC_LOAD: begin
                acc_nxt_s = in_a ^ in_b;
                acc_wr_s  = 1'b1;
                result_s  = acc_nxt_s;
            end
            default:     result_s = '0;
        endcase
    end

`ifdef LOGIC_UNIT_PARITY_EN
    assign wr_payload_s = {parity64(64'(result_s)), result_s};
    assign out_parity   = rd_payload_s[WIDTH];
`else
    assign wr_payload_s = result_s;
`endif
    assign out_data = rd_payload_s[WIDTH-1:0];

    // Accumulator moves only on an accepted accumulator op; flushed beats never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (accept_s && acc_wr_s) begin
            acc_r <= acc_nxt_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    logic_unit_fifo2 #(
        .W (PW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_valid  (in_valid),
        .wr_data   (wr_payload_s),
        .wr_ready  (in_ready),
        .wr_accept (accept_s),
        .rd_valid  (out_valid),
        .rd_data   (rd_payload_s),
        .rd_ready  (out_ready)
    );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=32) with a result scoreboard.
module tb_logic_unit_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
`ifdef LOGIC_UNIT_PARITY_EN
    logic         out_parity;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] acc_m;
    logic [W-1:0] hold_data;
    logic         hold_armed;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef LOGIC_UNIT_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted beat, including the accumulator.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r);
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = ~(a | b);
            3'b100: r = ~(a ^ b);
            3'b101: r = a & ~b;
            3'b110: begin acc_m = acc_m ^ a ^ b; r = acc_m; end
            default: begin acc_m = a ^ b; r = acc_m; end
        endcase
    endtask

    // Present one beat for one cycle; returns whether it was accepted.
    task automatic beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic accepted);
        logic [W-1:0] r;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        accepted = in_ready && !flush;
        if (accepted) begin
            model(op, a, b, r);
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check(tag, {63'd0, (exp_q.size() == 0 && !out_valid)}, 64'd1);
    endtask

    // Scoreboard pop on every completed output handshake, plus hold-while-stalled check.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            hold_armed = 1'b0;
        end else begin
            if (hold_armed) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", 64'(out_data), 64'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e));
`ifdef LOGIC_UNIT_PARITY_EN
                    check("out_parity", {63'd0, out_parity}, {63'd0, ^e});
`endif
                end
            end
            hold_armed = out_valid && !out_ready && !flush;
            hold_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic a0, a1, a2;
        logic [2:0]   ops [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010};
        logic [W-1:0] as  [6] = '{32'hF0F0_1234, 32'h0000_00FF, 32'h8000_0001, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [W-1:0] bs  [6] = '{32'hFF00_0F0F, 32'h1200_0000, 32'h0000_0100, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h0000_0000};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        flush = 1'b0; out_ready = 1'b0; acc_m = '0; hold_armed = 1'b0; hold_data = '0;

        // Reset state.
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("pre_edge_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("post_edge_in_ready", {63'd0, in_ready}, 64'd1);

        // XOR with one-cycle latency.
        out_ready = 1'b1;
        beat(3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, a0);
        check("xor_accept", {63'd0, a0}, 64'd1);
        check("xor_latency_valid", {63'd0, out_valid}, 64'd1);
        check("xor_latency_data", 64'(out_data), 64'h0000_0000_F0F0_0F0F);

        // Remaining plain ops back to back (accept and leave together at count 1).
        for (int i = 0; i < 6; i++) begin
            beat(ops[i], as[i], bs[i], a0);
            check("ops_accept", {63'd0, a0}, 64'd1);
        end
        drain("ops_drain");

        // Accumulator: 0x12345678 ^ 0xFF ^ 0xF00 = 0x12345987.
        beat(3'b111, 32'h1234_5678, 32'h0000_0000, a0);
        check("accload_data", 64'(out_data), 64'h0000_0000_1234_5678);
        beat(3'b110, 32'h0000_00FF, 32'h0000_0F00, a1);
        check("accxor_data", 64'(out_data), 64'h0000_0000_1234_5987);
        drain("acc_drain");

        // Back-pressure: two accepted, third refused, then drained in order.
        out_ready = 1'b0;
        beat(3'b000, 32'h1111_FFFF, 32'hFFFF_2222, a0);
        beat(3'b001, 32'h3300_0000, 32'h0000_0044, a1);
        beat(3'b101, 32'hFFFF_FFFF, 32'h0000_FFFF, a2);
        check("bp_accept0", {63'd0, a0}, 64'd1);
        check("bp_accept1", {63'd0, a1}, 64'd1);
        check("bp_refuse2", {63'd0, a2}, 64'd0);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("bp_drain");

        // Flush at count 2 with a pending input beat.
        out_ready = 1'b0;
        beat(3'b010, 32'h0000_0001, 32'h0000_0002, a0);
        beat(3'b010, 32'h0000_0003, 32'h0000_0004, a1);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'b111; in_a = 32'hDEAD_BEEF; in_b = 32'h0;
        @(negedge clk);
        check("flush2_in_ready", {63'd0, in_ready}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush2_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("flush2_in_ready_back", {63'd0, in_ready}, 64'd1);

        // Flush at count 1 while in_ready=1: the ACC_LOAD beat must be dropped.
        beat(3'b000, 32'h0000_00F0, 32'h0000_0FF0, a0);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'b111; in_a = 32'hCAFE_F00D; in_b = 32'h0;
        @(negedge clk);
        check("flush1_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Accumulator must still hold 0x12345987: ^0x1^0x2 -> 0x12345984.
        out_ready = 1'b1;
        beat(3'b110, 32'h0000_0001, 32'h0000_0002, a0);
        check("flush_acc_kept", 64'(out_data), 64'h0000_0000_1234_5984);
        drain("flush_drain");

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        beat(3'b000, 32'h1234_0000, 32'hFFFF_0000, a0);
        beat(3'b001, 32'h0000_0056, 32'h0000_7800, a1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef LOGIC_UNIT_PARITY_EN
        check("arst_out_parity", {63'd0, out_parity}, 64'd0);
`endif
        exp_q.delete();
        acc_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready_back", {63'd0, in_ready}, 64'd1);
        check("arst_no_stale", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        beat(3'b110, 32'h0000_00F0, 32'h0000_000F, a0);
        check("arst_acc_zero", 64'(out_data), 64'h0000_0000_0000_00FF);
        beat(3'b000, 32'h0000_0007, 32'h0000_0007, a1);
        check("and7_data", 64'(out_data), 64'h0000_0000_0000_0007);
`ifdef LOGIC_UNIT_PARITY_EN
        check("and7_parity", {63'd0, out_parity}, 64'd1);
`endif
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
